reg_dump_uart: RTL and testbench
================================

# reg_dump_uart

Debug serializer downstream of the CPU core: on a trigger it snapshots the 1024-bit register-file debug bus (32 × 32-bit registers, register n at bits [32n+31:32n]). It then transmits the snapshot as a framed byte stream over a UART TX line (8N1, LSB first). It lets the board dump the architectural register state to a host without halting the core.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (434 = 50 MHz / 115200); legal range ≥ 2.
- HEADER, 8'hA5: sync byte sent before the register data.

Ports:
- clk  input  1  system clock; one clock domain, all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- regs  input  1024  register-file debug bus from the core.
- trigger  input  1  request a dump; level sampled each cycle.
- tx  output  1  UART serial output, idle high.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse after the final stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- **Reset:** asserting reset_n=0 forces the following immediately (asynchronously), including mid-transfer. The partial frame is abandoned and no done pulse is generated.
  - tx=1, busy=0, done=0.
  - state=IDLE; byte index, bit index and baud counter = 0.
  - snapshot register = 0.
- **Accepting a dump (IDLE):** if trigger=1 at a clock edge, that same edge:
  - captures regs into a 1024-bit snapshot register;
  - sets byte index=0, busy=1, state=START.
  - Later changes on regs do not affect the stream.
- **Stream:** 129 bytes.
  - Byte 0 = HEADER.
  - Bytes 1..128 = registers 0..31 in ascending order, each most-significant byte first. Byte 4n+1 = snapshot[32n+31:32n+24], …, byte 4n+4 = snapshot[32n+7:32n].
- **Frame:** each byte is one 10-bit frame. Each bit holds tx for exactly CLKS_PER_BIT cycles.
  - START: tx=0.
  - DATA: tx = data bits 0..7, LSB first.
  - STOP: tx=1.
- **Between frames:** after STOP of byte k<128, go directly to START of byte k+1 with no idle gap.
- **End of stream:** after STOP of byte 128:
  - state=IDLE, busy=0;
  - done=1 for exactly one cycle.
- **Trigger handling:**
  - trigger while busy=1 is ignored (not queued).
  - trigger held high continuously starts a new dump on the first cycle after busy falls. The cycle where done=1 is in IDLE, so it accepts trigger.
- **Counters:**
  - Baud counter: width ceil(log2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1, then wraps.
  - Bit index: 3 bits.
  - Byte index: 8 bits, range 0..128.

## Timing
- tx, busy and done are registered outputs; there are no combinational paths from inputs to outputs.
- Let trigger be sampled high at edge T0.
  - busy=1 and tx=0 (start bit) from just after T0.
  - The start bit of byte 0 occupies edges T0..T0+CLKS_PER_BIT.
- Byte k's start bit begins at T0 + 10·k·CLKS_PER_BIT.
- Last stop bit ends at T0 + 1290·CLKS_PER_BIT. At that edge: busy→0, done→1, tx stays 1.
- At edge T0 + 1290·CLKS_PER_BIT + 1: done→0.
- Total dump latency: 1290·CLKS_PER_BIT cycles. Back-to-back dumps are separated by exactly one IDLE cycle.

## Test plan
Use CLKS_PER_BIT=4 unless noted. The bench decodes tx with a UART receive model.

1. **Reset values:** hold reset_n=0 → tx=1, busy=0, done=0.
   - Release reset, no trigger for 100 cycles → outputs unchanged.
2. **Basic dump:** regs with register n = 32'h01020300 + n; pulse trigger one cycle.
   - Receiver gets A5, 01 02 03 00, 01 02 03 01, …, 01 02 03 1F (129 bytes).
   - busy high for exactly 5160 cycles; done pulses once at cycle 5160 after the trigger edge.
3. **Snapshot isolation:** start a dump with all regs = 0, then drive regs = all-ones from the next cycle.
   - Received data bytes are all 00.
4. **Ignored trigger:** pulse trigger again at cycles 100 and 5159 of a dump.
   - Exactly one stream of 129 bytes; no second dump starts.
   - Holding trigger high continuously instead: the second A5 start bit begins exactly 1 cycle after done.
5. **Reset mid-operation:** assert reset_n=0 during the data bits of byte 50.
   - tx=1 and busy=0 immediately; no done pulse.
   - A new trigger after release yields a complete, correct 129-byte stream.
6. **Bit timing:** with CLKS_PER_BIT=434, measure the A5 frame.
   - Start bit low for 434 cycles.
   - Bit pattern 1,0,1,0,0,1,0,1; each bit 434 cycles.
   - Stop bit 434 cycles.

Source files
------------

// File: rtl/reg_dump_uart.sv
// Register-file dump serializer: snapshots the 1024-bit debug bus on a trigger
// and streams a header byte plus 128 register bytes out as 8N1 UART frames.
`timescale 1ns/1ps

module reg_dump_uart #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [1023:0] regs,
   input  logic          trigger,
   output logic          tx,
   output logic          busy,
   output logic          done
);

   localparam int               BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [7:0]       LAST_BYTE = 8'd128;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e              state_q, state_d;
   logic [1023:0]       snap_q, snap_d;
   logic [7:0]          byte_idx_q, byte_idx_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [6:0]          data_idx;
   logic [7:0]          cur_byte;
   logic                baud_done;

   // Byte k>0 is byte (3 - (k-1)%4) of register (k-1)/4, so MSB first per register.
   always_comb begin
      data_idx = byte_idx_q[6:0] - 7'd1;
      cur_byte = (byte_idx_q == 8'd0) ? HEADER
                                      : snap_q[{data_idx[6:2], ~data_idx[1:0], 3'b000} +: 8];
   end

   assign baud_done = (baud_q == BAUD_LAST);

   // NOTE: every _d gets its default first, so no path through the case can infer a latch.
   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      baud_d     = '0;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = baud_done ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               snap_d     = regs;
               byte_idx_d = 8'd0;
               bit_idx_d  = 3'd0;
               busy_d     = 1'b1;
               tx_d       = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = cur_byte[bit_idx_q + 3'd1];
               end
            end
         end
         S_STOP: begin
            if (baud_done) begin
               if (byte_idx_q == LAST_BYTE) begin
                  byte_idx_d = 8'd0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  // Next frame's start bit follows the stop bit with no idle gap.
                  byte_idx_d = byte_idx_q + 8'd1;
                  tx_d       = 1'b0;
                  state_d    = S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the wide snapshot is reset too, so a dump can never expose stale pre-reset data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         snap_q     <= '0;
         byte_idx_q <= 8'd0;
         bit_idx_q  <= 3'd0;
         baud_q     <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         baud_q     <= baud_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: cycle-level stream model, UART receive decoder and
// a fast-baud plus a full-rate instance for exact bit timing.
`timescale 1ns/1ps

module tb_reg_dump_uart;

   localparam int CPB_A   = 4;
   localparam int CPB_B   = 434;
   localparam int TOTAL_A = 1290 * CPB_A;

   logic          clk = 1'b0;
   logic          reset_n, reset_n_b;
   logic [1023:0] regs, regs_b;
   logic          trigger, trigger_b;
   logic          tx, busy, done;
   logic          tx_b, busy_b, done_b;

   int            n_cmp = 0;
   int            n_bad = 0;
   bit            cmp_en = 1'b0;

   always #5 clk = ~clk;

   reg_dump_uart #(.CLKS_PER_BIT(CPB_A), .HEADER(8'hA5)) dut_a (
      .clk(clk), .reset_n(reset_n), .regs(regs), .trigger(trigger),
      .tx(tx), .busy(busy), .done(done));

   reg_dump_uart #(.CLKS_PER_BIT(CPB_B), .HEADER(8'hA5)) dut_b (
      .clk(clk), .reset_n(reset_n_b), .regs(regs_b), .trigger(trigger_b),
      .tx(tx_b), .busy(busy_b), .done(done_b));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stream byte k of a dump taken from register image r.
   function automatic logic [7:0] exp_byte(input logic [1023:0] r, input int k);
      int reg_n, pos;
      if (k == 0) return 8'hA5;
      reg_n = (k - 1) / 4;
      pos   = (k - 1) % 4;
      return r[32*reg_n + 8*(3 - pos) +: 8];
   endfunction

   // Model: time since the accepting edge fully determines the line level.
   bit         m_active = 1'b0;
   bit         m_done   = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_bytes [129];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_t      = 0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            m_t++;
            if (m_t == TOTAL_A) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end else if (trigger) begin
            m_active = 1'b1;
            m_t      = 0;
            for (int k = 0; k < 129; k++) m_bytes[k] = exp_byte(regs, k);
         end
      end
   end

   function automatic logic model_tx();
      int b, k, p;
      if (!m_active) return 1'b1;
      b = m_t / CPB_A;
      k = b / 10;
      p = b % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return m_bytes[k][p-1];
   endfunction

   int  done_cnt  = 0;
   int  busy_cnt  = 0;
   time done_time = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("tx",   tx,   model_tx());
         check("busy", busy, m_active);
         check("done", done, m_done);
      end
      if (done) begin
         done_cnt++;
         done_time = $time;
      end
      if (busy) busy_cnt++;
   end

   // UART receive model: finds a start bit, samples mid-bit.
   logic [7:0] rx_q [$];

   task automatic rx_bytes(input int n);
      int         w;
      logic [7:0] d;
      rx_q.delete();
      for (int b = 0; b < n; b++) begin
         w = 0;
         while (tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
         end
         if (tx !== 1'b0) begin
            check("rx_start_seen", tx, 1'b0);
            return;
         end
         repeat (CPB_A / 2) @(negedge clk);
         check("rx_start_mid", tx, 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB_A) @(negedge clk);
            d[i] = tx;
         end
         repeat (CPB_A) @(negedge clk);
         check("rx_stop", tx, 1'b1);
         rx_q.push_back(d);
      end
   endtask

   task automatic check_stream(input logic [1023:0] r);
      check("rx_count", rx_q.size(), 129);
      for (int k = 0; k < rx_q.size(); k++)
         check($sformatf("rx_byte[%0d]", k), rx_q[k], exp_byte(r, k));
   endtask

   time t_trig;
   task automatic pulse_trigger();
      trigger = 1'b1;
      @(posedge clk);
      t_trig = $time;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((busy !== 1'b0 || done !== 1'b0) && w < 2 * TOTAL_A) begin
         @(negedge clk);
         w++;
      end
      check("wait_idle_busy", busy, 1'b0);
      repeat (5) @(negedge clk);
   endtask

   function automatic logic [1023:0] rand_regs();
      logic [1023:0] r;
      for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1023:0] r;
      int            d0, w;
      logic          samples [CPB_B*10 + 1];
      logic          lv [10];
      int            cnt;

      reset_n   = 1'b1;
      reset_n_b = 1'b1;
      trigger   = 1'b0;
      trigger_b = 1'b0;
      regs      = '0;
      regs_b    = '0;
      #2;
      reset_n   = 1'b0;
      reset_n_b = 1'b0;
      #1;
      // 1. Reset values, then a quiet idle period.
      check("rst_tx",   tx,   1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      repeat (3) @(negedge clk);
      cmp_en    = 1'b1;
      reset_n   = 1'b1;
      reset_n_b = 1'b1;
      repeat (100) @(negedge clk);
      check("idle_tx",   tx,   1'b1);
      check("idle_busy", busy, 1'b0);

      // 2. Basic dump with register n = 01020300 + n.
      for (int n = 0; n < 32; n++) regs[32*n +: 32] = 32'h0102_0300 + n;
      busy_cnt = 0;
      d0 = done_cnt;
      fork
         pulse_trigger();
         rx_bytes(129);
      join
      wait_idle();
      check("basic_count", rx_q.size(), 129);
      if (rx_q.size() == 129) begin
         check("basic_hdr", rx_q[0], 8'hA5);
         for (int n = 0; n < 32; n++) begin
            check("basic_b0", rx_q[4*n+1], 8'h01);
            check("basic_b1", rx_q[4*n+2], 8'h02);
            check("basic_b2", rx_q[4*n+3], 8'h03);
            check("basic_b3", rx_q[4*n+4], 8'(n));
         end
      end
      check("basic_busy_len", busy_cnt, 5160);
      check("basic_done_cnt", done_cnt - d0, 1);
      check("basic_done_lat", (done_time - t_trig - 5) / 10, 5160);

      // 3. Snapshot isolation.
      regs = '0;
      fork
         begin
            pulse_trigger();
            regs = '1;
         end
         rx_bytes(129);
      join
      wait_idle();
      check("iso_count", rx_q.size(), 129);
      for (int k = 1; k < rx_q.size(); k++) check("iso_byte", rx_q[k], 8'h00);

      // 4. Ignored triggers at cycles 100 and 5159 of a dump.
      r    = rand_regs();
      regs = r;
      d0   = done_cnt;
      fork
         begin
            pulse_trigger();
            repeat (99) @(negedge clk);
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            repeat (5058) @(negedge clk);
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
         end
         rx_bytes(129);
      join
      check_stream(r);
      wait_idle();
      repeat (50) @(negedge clk);
      check("ign_busy", busy, 1'b0);
      check("ign_done_cnt", done_cnt - d0, 1);

      // 4b. Trigger held high: restart one cycle after done.
      r       = rand_regs();
      regs    = r;
      trigger = 1'b1;
      rx_bytes(129);
      check_stream(r);
      w = 0;
      while (done !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("hold_done", done, 1'b1);
      check("hold_done_tx", tx, 1'b1);
      @(negedge clk);
      check("hold_restart_tx",   tx,   1'b0);
      check("hold_restart_busy", busy, 1'b1);
      trigger = 1'b0;
      rx_bytes(129);
      check_stream(r);
      wait_idle();

      // 5. Reset during the data bits of byte 50.
      r    = rand_regs();
      regs = r;
      pulse_trigger();
      repeat (500 * CPB_A + 10) @(negedge clk);
      d0 = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx",   tx,   1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_rst_no_done", done_cnt - d0, 0);
      r    = rand_regs();
      regs = r;
      fork
         pulse_trigger();
         rx_bytes(129);
      join
      check_stream(r);
      wait_idle();

      // 6. Full-rate bit timing of the A5 frame.
      lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      regs_b    = rand_regs();
      trigger_b = 1'b1;
      @(negedge clk);
      trigger_b = 1'b0;
      for (int i = 0; i <= CPB_B * 10; i++) begin
         samples[i] = tx_b;
         @(negedge clk);
      end
      for (int s = 0; s < 10; s++) begin
         cnt = 0;
         for (int i = s * CPB_B; i < (s + 1) * CPB_B; i++)
            if (samples[i] === lv[s]) cnt++;
         check($sformatf("b_slot%0d_len", s), cnt, CPB_B);
      end
      check("b_next_start", samples[CPB_B*10], 1'b0);
      reset_n_b = 1'b0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
